logo_bounce_ctrl: RTL and testbench
===================================

# logo_bounce_ctrl

Frame-rate controller that moves the 23×9-cell TT08 logo overlay around the 640×480 screen in a bouncing pattern, screensaver style. It produces the overlay origin in 8-pixel cell units, plus a visibility/blink enable, for the logo text renderer. The renderer subtracts the origin from the pixel cell coordinates. The block sits beside the VGA timing generator and updates state only once per frame, so the picture never tears.

## Interface
- `SPEED_DIV`, default 2: frame ticks per one-cell step (≥1).
- `HOLD_FRAMES`, default 60: frame ticks the logo rests at the start position before moving.
- `FLASH_FRAMES`, default 16: blink duration after a wall hit; doubled on a corner hit.
- `START_X`, default 30: reset cell column.
- `START_Y`, default 24: reset cell row.
- `clk` in 1: pixel clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ena` in 1: block enable; low forces hidden/idle.
- `frame_tick` in 1: one-cycle pulse at start of vertical blank, from the timing generator.
- `pause` in 1: freezes all frame-tick-driven activity.
- `org_x` out 7: logo origin column, range 0..57.
- `org_y` out 6: logo origin row, range 0..51.
- `visible` out 1: overlay enable to the renderer.
- `hit` out 1: one-cycle pulse when either axis reaches a wall.
- `corner` out 1: one-cycle pulse when both axes reach walls on the same step.

## Operation
- Effective tick: `tk = frame_tick & ~pause & ena`. Every high cycle of `frame_tick` counts as a separate tick.
- Limits: `MAX_X = H_CELLS − LOGO_W = 57`; `MAX_Y = V_CELLS − LOGO_H = 51`.
- Reset values:
  - `org_x = START_X`, `org_y = START_Y`
  - `dx = +1`, `dy = +1`
  - `visible = 0`, `hit = 0`, `corner = 0`
  - state `IDLE`; all counters 0
- `IDLE`: `visible = 0`. On `tk`, go to `HOLD`, set `visible = 1`, clear the hold counter.
- `HOLD`: count `tk`. When the count reaches `HOLD_FRAMES`, go to `MOVE` and clear the divider.
- `MOVE` and `FLASH`: count `tk` in the divider. When the divider reaches `SPEED_DIV − 1`, wrap it to 0 and take a step:
  - `org_x += dx` and `org_y += dy`, computed modulo-free. Direction is always toward the interior, so no overflow.
  - If the new `org_x` is 0 or `MAX_X`, negate `dx` in the same cycle. Same rule for `org_y` with `MAX_Y` and `dy`.
  - Any boundary hit pulses `hit`. A hit on both axes also pulses `corner`.
  - On a hit, enter or restart `FLASH` with the flash counter set to `FLASH_FRAMES`, or `2×FLASH_FRAMES` on a corner hit.
- `FLASH`:
  - Decrement the flash counter on each `tk`.
  - `visible = ~flash_cnt[2]`, so the logo toggles every 4 ticks.
  - At 0, return to `MOVE` with `visible = 1`.
  - Movement continues during `FLASH`.
- `ena` low, in any state: go to `IDLE` on the next clock. `visible = 0`; position and direction are retained; the hold, flash and divider counters are cleared.
- `pause` high: outputs hold their values; no counters advance.
- `START_X`/`START_Y` outside 1..MAX−1 is illegal (elaboration check).

## Timing
- All outputs are registered.
- Position, `visible`, `hit` and `corner` change only on the clock edge that samples `tk = 1`, or on the edge after `ena` falls.
- Latency: new origin values appear one cycle after the `frame_tick` cycle, well inside vertical blank.
- `hit` and `corner` are high for exactly the cycle in which the new boundary position is first output.
- Asynchronous reset mid-frame or mid-flash: all outputs go to their reset values immediately. Normal operation resumes on the first clock edge after `rst_n` rises.

## Structure
- Shared package `tt_vga_pkg` holds:
  - `H_CELLS = 80`, `V_CELLS = 60`, `LOGO_W = 23`, `LOGO_H = 9`
  - the state enum `{IDLE, HOLD, MOVE, FLASH}`
- Sub-module `axis_bouncer`, instantiated once per axis:
  - parameters: width, max, start
  - inputs: step strobe
  - outputs: position, direction, wall pulse
- Top level holds the FSM, divider, hold counter and flash counter.

## Test plan
- Reset, then `ena = 1`, then 1 tick → `visible = 1`, origin (30,24). After 60 further ticks the state is `MOVE`. The 2nd `MOVE` tick gives origin (31,25).
- From start with defaults: after 54 `MOVE` ticks → origin (57,51), `hit = 1` and `corner = 1` for one cycle, `dx = dy = −1`, `visible` blinks for 32 ticks and then stays 1.
- `START_X = 30`, `START_Y = 10`: first wall is x = 57 at step 27 → `hit = 1`, `corner = 0`, y = 37, 16-tick flash. The next step gives origin (56,38).
- `pause = 1` for 10 ticks during `MOVE` → origin, divider and `visible` are unchanged; motion resumes with the same phase once `pause = 0`.
- Drop `ena` during `FLASH` → next cycle `visible = 0` and state is `IDLE`. Re-enable → 60-tick `HOLD` at the retained position.
- Assert `rst_n = 0` for 3 cycles mid-move, unaligned to the clock → outputs return to (30,24), `visible = 0` immediately; no `hit` glitch.

Source files
------------

// File: rtl/tt_vga_pkg.sv
// Screen and logo geometry in 8-pixel cells, plus the
// bounce controller state encoding.
package tt_vga_pkg;

  localparam int H_CELLS = 80;
  localparam int V_CELLS = 60;
  localparam int LOGO_W  = 23;
  localparam int LOGO_H  = 9;
  localparam int MAX_X   = H_CELLS - LOGO_W;
  localparam int MAX_Y   = V_CELLS - LOGO_H;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    MOVE,
    FLASH
  } bounce_state_t;

endpackage

// File: rtl/axis_bouncer.sv
// One axis of the bouncing origin: position, direction and
// wall detection, advanced by a single-cycle step strobe.
module axis_bouncer #(
  parameter int W     = 7,
  parameter int MAX   = 57,
  parameter int START = 30
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  output logic [W-1:0] pos,
  output logic         dir,
  output logic         wall,
  output logic         bump
);

  if (START < 1 || START > MAX - 1) begin : g_bad_start
    $error("axis_bouncer START out of range");
  end

  logic [W-1:0] nxt;
  logic         at_edge;

  // dir = 1 means moving toward 0
  assign nxt     = dir ? pos - W'(1) : pos + W'(1);
  assign at_edge = (nxt == '0) || (nxt == W'(MAX));
  assign bump    = step & at_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos  <= W'(START);
      dir  <= 1'b0;
      wall <= 1'b0;
    end else begin
      wall <= bump;
      if (step) pos <= nxt;
      if (bump) dir <= ~dir;
    end
  end

endmodule

// File: rtl/logo_bounce_ctrl.sv
// Frame-rate bouncing-logo controller: hold, move and blink
// phases driving the overlay origin and visibility.
module logo_bounce_ctrl
  import tt_vga_pkg::*;
#(
  parameter int SPEED_DIV    = 2,
  parameter int HOLD_FRAMES  = 60,
  parameter int FLASH_FRAMES = 16,
  parameter int START_X      = 30,
  parameter int START_Y      = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       frame_tick,
  input  logic       pause,
  output logic [6:0] org_x,
  output logic [5:0] org_y,
  output logic       visible,
  output logic       hit,
  output logic       corner
);

  localparam int DW = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam int FC = $clog2(2 * FLASH_FRAMES + 1);
  localparam int FW = (FC > 3) ? FC : 3;

  localparam logic [DW-1:0] DIV_LAST  = DW'(SPEED_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);
  localparam logic [FW-1:0] FL_WALL   = FW'(FLASH_FRAMES);
  localparam logic [FW-1:0] FL_CORNER = FW'(2 * FLASH_FRAMES);

  bounce_state_t state_q, state_n;
  logic [DW-1:0] div_q, div_n;
  logic [HW-1:0] hold_q, hold_n;
  logic [FW-1:0] flash_q, flash_n, flash_dec, flash_ld;
  logic          vis_q, vis_n;

  logic tk, moving, step;
  logic bump_x, bump_y;
  logic wall_x, wall_y;
  logic dir_x, dir_y;

  assign tk     = frame_tick & ~pause & ena;
  assign moving = (state_q == MOVE) || (state_q == FLASH);
  assign step   = tk & moving & (div_q == DIV_LAST);

  axis_bouncer #(
    .W    (7),
    .MAX  (MAX_X),
    .START(START_X)
  ) u_x (
    .clk  (clk),
    .rst_n(rst_n),
    .step (step),
    .pos  (org_x),
    .dir  (dir_x),
    .wall (wall_x),
    .bump (bump_x)
  );

  axis_bouncer #(
    .W    (6),
    .MAX  (MAX_Y),
    .START(START_Y)
  ) u_y (
    .clk  (clk),
    .rst_n(rst_n),
    .step (step),
    .pos  (org_y),
    .dir  (dir_y),
    .wall (wall_y),
    .bump (bump_y)
  );

  assign hit     = wall_x | wall_y;
  assign corner  = wall_x & wall_y;
  assign visible = vis_q;

  assign flash_dec = flash_q - FW'(1);
  assign flash_ld  = (bump_x & bump_y) ? FL_CORNER : FL_WALL;

  always_comb begin
    state_n = state_q;
    div_n   = div_q;
    hold_n  = hold_q;
    flash_n = flash_q;
    vis_n   = vis_q;
    if (!ena) begin
      state_n = IDLE;
      vis_n   = 1'b0;
      div_n   = '0;
      hold_n  = '0;
      flash_n = '0;
    end else if (tk) begin
      unique case (state_q)
        IDLE: begin
          state_n = HOLD;
          vis_n   = 1'b1;
          hold_n  = '0;
        end
        HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_n = MOVE;
            div_n   = '0;
            hold_n  = '0;
          end else begin
            hold_n = hold_q + HW'(1);
          end
        end
        MOVE, FLASH: begin
          div_n = step ? '0 : div_q + DW'(1);
          if (state_q == FLASH) begin
            flash_n = flash_dec;
            if (flash_dec == '0) begin
              state_n = MOVE;
              vis_n   = 1'b1;
            end else begin
              vis_n = ~flash_dec[2];
            end
          end
          // a fresh wall hit restarts the blink window
          if (bump_x | bump_y) begin
            state_n = FLASH;
            flash_n = flash_ld;
            vis_n   = ~flash_ld[2];
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      hold_q  <= '0;
      flash_q <= '0;
      vis_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      div_q   <= div_n;
      hold_q  <= hold_n;
      flash_q <= flash_n;
      vis_q   <= vis_n;
    end
  end

endmodule

// File: tb/tb_logo_bounce_ctrl.sv
// Directed bench for logo_bounce_ctrl: default instance plus
// a START_Y=10 instance sharing the same stimulus.
module tb_logo_bounce_ctrl;
  import tt_vga_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       frame_tick = 1'b0;
  logic       pause = 1'b0;
  logic [6:0] org_x, org_x2;
  logic [5:0] org_y, org_y2;
  logic       visible, visible2;
  logic       hit, hit2;
  logic       corner, corner2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  logo_bounce_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .frame_tick(frame_tick),
    .pause     (pause),
    .org_x     (org_x),
    .org_y     (org_y),
    .visible   (visible),
    .hit       (hit),
    .corner    (corner)
  );

  logo_bounce_ctrl #(.START_Y(10)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .frame_tick(frame_tick),
    .pause     (pause),
    .org_x     (org_x2),
    .org_y     (org_y2),
    .visible   (visible2),
    .hit       (hit2),
    .corner    (corner2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_x", int'(org_x), 30);
    chk("rst_y", int'(org_y), 24);
    chk("rst_vis", int'(visible), 0);
    chk("rst_hit", int'(hit), 0);
    chk("rst_corner", int'(corner), 0);

    rst_n = 1'b1;
    ena   = 1'b1;
    tick(1);
    chk("idle_vis", int'(visible), 1);
    chk("idle_x", int'(org_x), 30);
    chk("idle_y", int'(org_y), 24);
    tick(59);
    chk("hold_59", int'(dut.state_q), int'(HOLD));
    tick(1);
    chk("hold_60", int'(dut.state_q), int'(MOVE));
    tick(1);
    chk("mv1_x", int'(org_x), 30);
    tick(1);
    chk("mv2_x", int'(org_x), 31);
    chk("mv2_y", int'(org_y), 25);

    tick(1);
    pause = 1'b1;
    tick(10);
    chk("pz_x", int'(org_x), 31);
    chk("pz_y", int'(org_y), 25);
    chk("pz_div", int'(dut.div_q), 1);
    chk("pz_vis", int'(visible), 1);
    pause = 1'b0;
    tick(1);
    chk("rs_x", int'(org_x), 32);
    chk("rs_y", int'(org_y), 26);

    tick(49);
    chk("pre_x", int'(org_x), 56);
    chk("pre_hit", int'(hit), 0);
    tick(1);
    chk("cn_x", int'(org_x), 57);
    chk("cn_y", int'(org_y), 51);
    chk("cn_hit", int'(hit), 1);
    chk("cn_corner", int'(corner), 1);
    chk("w2_x", int'(org_x2), 57);
    chk("w2_y", int'(org_y2), 37);
    chk("w2_hit", int'(hit2), 1);
    chk("w2_corner", int'(corner2), 0);
    @(negedge clk);
    chk("cn_hit_end", int'(hit), 0);
    chk("cn_corner_end", int'(corner), 0);
    chk("dx_neg", int'(dut.u_x.dir), 1);
    chk("dy_neg", int'(dut.u_y.dir), 1);

    tick(1);
    chk("fl1_vis", int'(visible), 0);
    chk("fl1_vis2", int'(visible2), 0);
    tick(1);
    chk("s28_x", int'(org_x), 56);
    chk("s28_y", int'(org_y), 50);
    chk("s28_x2", int'(org_x2), 56);
    chk("s28_y2", int'(org_y2), 38);
    tick(10);
    chk("fl12_vis", int'(visible), 0);
    tick(4);
    chk("fl16_st2", int'(dut2.state_q), int'(MOVE));
    chk("fl16_vis2", int'(visible2), 1);
    chk("fl16_st", int'(dut.state_q), int'(FLASH));
    chk("fl16_vis", int'(visible), 1);
    chk("fl16_x", int'(org_x), 49);
    tick(4);
    chk("fl20_vis", int'(visible), 0);

    ena = 1'b0;
    @(negedge clk);
    chk("off_vis", int'(visible), 0);
    chk("off_st", int'(dut.state_q), int'(IDLE));
    chk("off_x", int'(org_x), 47);
    chk("off_y", int'(org_y), 41);

    ena = 1'b1;
    tick(1);
    chk("re_vis", int'(visible), 1);
    chk("re_x", int'(org_x), 47);
    tick(59);
    chk("re_hold", int'(dut.state_q), int'(HOLD));
    tick(1);
    chk("re_move", int'(dut.state_q), int'(MOVE));
    tick(2);
    chk("re_x2", int'(org_x), 46);
    chk("re_y2", int'(org_y), 40);

    tick(1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_x", int'(org_x), 30);
    chk("ar_y", int'(org_y), 24);
    chk("ar_vis", int'(visible), 0);
    chk("ar_hit", int'(hit), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ar_st", int'(dut.state_q), int'(IDLE));
    chk("ar_vis2", int'(visible), 0);
    chk("ar_hit2", int'(hit), 0);
    tick(1);
    chk("ar_run", int'(visible), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
